// File: rtl/lea_pkg.sv
// LEA-128 shared definitions: schedule constants, round count,
// key-sequencer state encoding and the 32-bit rotate helper.
package lea_pkg;

    localparam int NR = 24;

    localparam logic [31:0] LEA_DELTA [4] = '{
        32'hc3efe9db,
        32'h44626b02,
        32'h79e27c8a,
        32'h78df30ec
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_EMIT   = 2'd2
    } lea_ks_state_t;

    // Shifts by 32 yield zero, so n == 0 returns x unchanged.
    function automatic logic [31:0] rol32(
        input logic [31:0] x,
        input logic [4:0]  n
    );
        return (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

endpackage

// File: rtl/lea_key_round.sv
// One combinational LEA-128 key schedule step: advances T[0..3]
// for round i and packs the resulting 192-bit round key.
module lea_key_round (
    input  logic [3:0][31:0] t_i,
    input  logic [4:0]       rnd_i,
    output logic [3:0][31:0] t_o,
    output logic [191:0]     rk_o
);
    import lea_pkg::*;

    logic [31:0] d;

    assign d = LEA_DELTA[rnd_i[1:0]];

    // 5-bit round sums wrap, giving rotation amounts mod 32.
    assign t_o[0] = rol32(t_i[0] + rol32(d, rnd_i), 5'd1);
    assign t_o[1] = rol32(t_i[1] + rol32(d, rnd_i + 5'd1), 5'd3);
    assign t_o[2] = rol32(t_i[2] + rol32(d, rnd_i + 5'd2), 5'd6);
    assign t_o[3] = rol32(t_i[3] + rol32(d, rnd_i + 5'd3), 5'd11);

    assign rk_o = {t_o[1], t_o[3], t_o[1], t_o[2], t_o[1], t_o[0]};

endmodule

// File: rtl/lea_dec_key_sequencer.sv
// LEA-128 decryption key sequencer: expands all round keys into
// local storage, then streams them out from the last round down.
module lea_dec_key_sequencer #(
    parameter int NR = lea_pkg::NR,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [127:0]  key_in,
    input  logic          key_valid,
    output logic          key_ready,
    input  logic          replay,
    output logic [191:0]  rk_out,
    output logic          rk_valid,
    input  logic          rk_ready,
    output logic [RW-1:0] rk_round,
    output logic          rk_last,
    output logic          busy
);
    import lea_pkg::*;

    localparam logic [RW-1:0] TOP = RW'(NR - 1);

    lea_ks_state_t    state_q, state_d;
    logic [RW-1:0]    i_q, i_d;
    logic [RW-1:0]    idx_q, idx_d;
    logic [RW-1:0]    idx_m1;
    logic [3:0][31:0] t_q, t_d, t_nx;
    logic             loaded_q, loaded_d;
    logic [191:0]     rk_q, rk_d, rk_nx;
    logic [RW-1:0]    rnd_q, rnd_d;
    logic             last_q, last_d;
    logic [191:0]     mem_q [NR];

    lea_key_round u_round (
        .t_i   (t_q),
        .rnd_i (i_q[4:0]),
        .t_o   (t_nx),
        .rk_o  (rk_nx)
    );

    assign idx_m1 = idx_q - RW'(1);

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        idx_d    = idx_q;
        t_d      = t_q;
        loaded_d = loaded_q;
        rk_d     = rk_q;
        rnd_d    = rnd_q;
        last_d   = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    t_d      = key_in;
                    i_d      = '0;
                    loaded_d = 1'b0;
                    state_d  = ST_EXPAND;
                end else if (replay && loaded_q) begin
                    state_d = ST_EMIT;
                    idx_d   = TOP;
                    rk_d    = mem_q[TOP];
                    rnd_d   = TOP;
                    last_d  = (TOP == '0);
                end
            end
            ST_EXPAND: begin
                t_d = t_nx;
                i_d = i_q + RW'(1);
                // Final round key bypasses storage straight to the output.
                if (i_q == TOP) begin
                    loaded_d = 1'b1;
                    state_d  = ST_EMIT;
                    idx_d    = TOP;
                    rk_d     = rk_nx;
                    rnd_d    = TOP;
                    last_d   = (TOP == '0);
                end
            end
            ST_EMIT: begin
                if (rk_ready) begin
                    if (idx_q == '0) begin
                        state_d = ST_IDLE;
                        rk_d    = '0;
                        rnd_d   = '0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d  = idx_m1;
                        rk_d   = mem_q[idx_m1];
                        rnd_d  = idx_m1;
                        last_d = (idx_m1 == '0);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            i_q      <= '0;
            idx_q    <= '0;
            t_q      <= '0;
            loaded_q <= 1'b0;
            rk_q     <= '0;
            rnd_q    <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            idx_q    <= idx_d;
            t_q      <= t_d;
            loaded_q <= loaded_d;
            rk_q     <= rk_d;
            rnd_q    <= rnd_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_EXPAND) begin
            mem_q[i_q] <= rk_nx;
        end
    end

    assign key_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rk_valid  = (state_q == ST_EMIT);
    assign rk_out    = rk_q;
    assign rk_round  = rnd_q;
    assign rk_last   = last_q;

endmodule

// File: tb/tb_lea_dec_key_sequencer.sv
// Bench for the LEA-128 decryption key sequencer: scoreboard of
// expected beats fed from an independent key schedule model.
module tb_lea_dec_key_sequencer;

    typedef struct packed {
        logic [191:0] rk;
        logic [4:0]   rnd;
        logic         last;
    } exp_t;

    typedef struct {
        logic [127:0] key;
        int           stall;
        logic [191:0] rk0;
    } vec_t;

    logic         clk = 0;
    logic         rst_n = 0;
    logic [127:0] key_in = '0;
    logic         key_valid = 0;
    logic         key_ready;
    logic         replay = 0;
    logic [191:0] rk_out;
    logic         rk_valid;
    logic         rk_ready = 0;
    logic [4:0]   rk_round;
    logic         rk_last;
    logic         busy;

    int tests = 0;
    int fails = 0;
    exp_t sb [$];
    logic [191:0] exp_rk [24];

    lea_dec_key_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .replay    (replay),
        .rk_out    (rk_out),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_round  (rk_round),
        .rk_last   (rk_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [191:0] act,
                       input logic [191:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        int m;
        m = n % 32;
        if (m == 0) return x;
        return (x << m) | (x >> (32 - m));
    endfunction

    task automatic model_fill(input logic [127:0] k);
        logic [31:0] dl [4];
        logic [31:0] t [4];
        logic [31:0] d;
        dl = '{32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec};
        for (int j = 0; j < 4; j++) t[j] = k[32*j +: 32];
        for (int i = 0; i < 24; i++) begin
            d = dl[i % 4];
            t[0] = rotl(t[0] + rotl(d, i), 1);
            t[1] = rotl(t[1] + rotl(d, i + 1), 3);
            t[2] = rotl(t[2] + rotl(d, i + 2), 6);
            t[3] = rotl(t[3] + rotl(d, i + 3), 11);
            exp_rk[i] = {t[1], t[3], t[1], t[2], t[1], t[0]};
        end
    endtask

    task automatic push_beats(input logic [127:0] k);
        exp_t e;
        model_fill(k);
        for (int r = 23; r >= 0; r--) begin
            e.rk = exp_rk[r];
            e.rnd = 5'(r);
            e.last = (r == 0);
            sb.push_back(e);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_ctrl"}, 192'({key_ready, rk_valid, busy, rk_last, rk_round}),
            192'({1'b1, 1'b0, 1'b0, 1'b0, 5'd0}));
        chk({nm, "_rk"}, rk_out, 192'd0);
    endtask

    // Called at a falling edge; returns after the accepting rising edge.
    task automatic send_key(input logic [127:0] k, output int waited);
        waited = 0;
        key_in = k;
        key_valid = 1;
        while (!key_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!key_ready) chk("key_accept_timeout", 192'(key_ready), 192'd1);
        @(posedge clk);
        push_beats(k);
    endtask

    task automatic stream(input int stall_pct, input int lat_exp,
                          input logic hold, input logic [127:0] nxt,
                          output logic [191:0] lr);
        int cyc = 0;
        bit first = 1;
        bit done = 0;
        bit stalled = 0;
        logic [191:0] h_rk;
        logic [4:0] h_rnd;
        logic h_last;
        exp_t e;
        lr = '0;
        h_rk = '0;
        h_rnd = '0;
        h_last = 0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                replay = 0;
                if (hold) key_in = nxt;
                else key_valid = 0;
            end
            chk("key_ready_busy", 192'(key_ready), 192'd0);
            if (rk_valid) begin
                if (first) begin
                    first = 0;
                    chk("first_latency", 192'(cyc), 192'(lat_exp));
                end
                if (stalled) begin
                    chk("stall_rk", rk_out, h_rk);
                    chk("stall_meta", 192'({rk_round, rk_last}),
                        192'({h_rnd, h_last}));
                end
                rk_ready = ($urandom_range(99) >= stall_pct);
                if (rk_ready) begin
                    stalled = 0;
                    if (sb.size() == 0) begin
                        chk("sb_empty", 192'(sb.size()), 192'd1);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_rk", rk_out, e.rk);
                        chk("beat_meta", 192'({rk_round, rk_last}),
                            192'({e.rnd, e.last}));
                    end
                    if (rk_last) begin
                        done = 1;
                        lr = rk_out;
                        if (stall_pct == 0)
                            chk("last_cycle", 192'(cyc), 192'(lat_exp + 23));
                    end
                end else begin
                    stalled = 1;
                    h_rk = rk_out;
                    h_rnd = rk_round;
                    h_last = rk_last;
                end
            end else if (!first) begin
                chk("valid_dropped", 192'(rk_valid), 192'd1);
            end
        end
        if (!done) chk("stream_timeout", 192'(done), 192'd1);
        @(negedge clk);
        chk_idle("post_stream");
        chk("sb_drained", 192'(sb.size()), 192'd0);
    endtask

    // Called at a falling edge; asynchronous reset asserted immediately.
    task automatic do_reset(input string nm);
        rst_n = 0;
        key_valid = 0;
        replay = 0;
        rk_ready = 0;
        #1;
        chk_idle(nm);
        @(negedge clk);
        rst_n = 1;
        sb.delete();
    endtask

    task automatic replay_ignored(input string nm);
        replay = 1;
        @(negedge clk);
        replay = 0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk(nm, 192'({rk_valid, busy}), 192'd0);
        end
    endtask

    initial begin
        vec_t vt [4];
        logic [191:0] lr;
        logic [127:0] ka, kb, kc;
        int w;

        vt[0].key   = 128'hf0e1d2c3_b4a59687_78695a4b_3c2d1e0f;
        vt[0].stall = 0;
        vt[0].rk0   = {32'h02497010, 32'h090d0883, 32'h02497010,
                       32'h194f7db1, 32'h02497010, 32'h003a0fd4};
        for (int v = 1; v < 4; v++) begin
            vt[v].key = {$urandom, $urandom, $urandom, $urandom};
            vt[v].stall = (v == 1) ? 0 : 30 * v;
            model_fill(vt[v].key);
            vt[v].rk0 = exp_rk[0];
        end

        @(negedge clk);
        #1;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1;

        replay_ignored("replay_after_reset");

        for (int v = 0; v < 4; v++) begin
            send_key(vt[v].key, w);
            stream(vt[v].stall, 25, 1'b0, '0, lr);
            chk("round0_key", lr, vt[v].rk0);
        end

        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        kc = {$urandom, $urandom, $urandom, $urandom};

        send_key(ka, w);
        stream(0, 25, 1'b1, kb, lr);
        send_key(kb, w);
        chk("held_key_wait", 192'(w), 192'd0);
        stream(0, 25, 1'b0, '0, lr);

        replay = 1;
        push_beats(kb);
        @(posedge clk);
        stream(0, 1, 1'b0, '0, lr);
        replay = 1;
        push_beats(kb);
        @(posedge clk);
        stream(50, 1, 1'b0, '0, lr);

        replay = 1;
        send_key(kc, w);
        stream(0, 25, 1'b0, '0, lr);

        send_key(ka, w);
        @(negedge clk);
        key_valid = 0;
        repeat (9) @(negedge clk);
        chk("mid_expand_busy", 192'({busy, rk_valid}), 192'({1'b1, 1'b0}));
        do_reset("reset_mid_expand");
        replay_ignored("replay_after_expand_abort");
        send_key(kb, w);
        stream(20, 25, 1'b0, '0, lr);

        send_key(kc, w);
        @(negedge clk);
        key_valid = 0;
        rk_ready = 0;
        repeat (29) @(negedge clk);
        chk("mid_emit_valid", 192'({busy, rk_valid}), 192'({1'b1, 1'b1}));
        do_reset("reset_mid_emit");
        replay_ignored("replay_after_emit_abort");
        send_key(ka, w);
        stream(0, 25, 1'b0, '0, lr);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lea_dec_key_sequencer.md
# lea_dec_key_sequencer

Decryption-side LEA-128 key schedule. It accepts a 128-bit master key and expands all 24 192-bit round keys into local storage. It then streams them out in reverse order (round 23 down to round 0) on a valid/ready interface, so the LEA decryption datapath can consume one round key per round. It complements the encryption-side key constructor, which produces round keys in forward order.

## Interface
Parameters:
- `NR`, default 24: number of rounds (LEA-128). Fixed; other values are unsupported.
- `RW`, default 5: width of the round index.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `key_in` in 128: master key. `key_in[31:0]` = K[0], …, `key_in[127:96]` = K[3].
- `key_valid` in 1: master key offered.
- `key_ready` out 1: key accepted when `key_valid && key_ready`.
- `replay` in 1: single-cycle pulse in IDLE. Re-streams the stored keys without re-expansion.
- `rk_out` out 192: round key. `[31:0]`=RK0, `[63:32]`=RK1, … `[191:160]`=RK5.
- `rk_valid` out 1: `rk_out` is valid.
- `rk_ready` in 1: consumer accepts `rk_out`.
- `rk_round` out `RW`: round index of the key currently on `rk_out`.
- `rk_last` out 1: high with round 0 (the final beat).
- `busy` out 1: high in EXPAND or EMIT.

## Operation
- States: IDLE, EXPAND, EMIT.
- **IDLE**
  - `key_ready`=1.
  - On key handshake: latch T[0..3] = K[0..3], clear `i` to 0, go to EXPAND.
  - Else, on `replay` with `loaded`=1: go to EMIT with `idx`=23.
  - If `key_valid` and `replay` are both high, `key_valid` wins.
  - `replay` with `loaded`=0 is ignored.
- **EXPAND**
  - One step per cycle, with δ = {c3efe9db, 44626b02, 79e27c8a, 78df30ec}, d = δ[i mod 4], all additions mod 2^32:
    - T0 ← ROL1(T0 + ROL_i(d))
    - T1 ← ROL3(T1 + ROL_{i+1}(d))
    - T2 ← ROL6(T2 + ROL_{i+2}(d))
    - T3 ← ROL11(T3 + ROL_{i+3}(d))
  - Rotation amounts are taken mod 32.
  - Store mem[i] = {T1, T3, T1, T2, T1, T0}, MSB-first, using the updated T values.
  - After i=23 is written: set `loaded`=1, go to EMIT with `idx`=23.
- **EMIT**
  - `rk_out` = mem[idx], `rk_round` = idx, `rk_valid`=1, `rk_last` = (idx==0).
  - On handshake: if idx==0, go to IDLE; else idx ← idx−1.
- `key_ready`=0 outside IDLE. A key offered while busy is held off, never dropped or corrupted.
- When a new key is accepted, `loaded` clears to 0. It sets to 1 only after EXPAND completes.

## Timing
- Reset: state=IDLE, `key_ready`=1, `rk_valid`=0, `rk_out`=0, `rk_round`=0, `rk_last`=0, `busy`=0, `loaded`=0. Storage contents are don't-care.
- Key handshake at edge 0 → EXPAND during cycles 1–24 → `rk_valid`=1 with round 23 in cycle 25.
- With `rk_ready` held high: one key per cycle, 24 beats. Round 0 appears in cycle 48, and IDLE (`key_ready`=1) in cycle 49.
- The next key is accepted no earlier than cycle 49.
- `replay` in cycle n → round 23 valid in cycle n+1.
- While `rk_valid && !rk_ready`: `rk_out`, `rk_round` and `rk_last` are held stable.
- `rk_out`, `rk_round` and `rk_last` are registered. `rk_out` returns to 0 when leaving EMIT.
- `rst_n` low in any state aborts immediately: outputs take their reset values and the stored keys are invalidated (`loaded`=0).

## Structure
- Package `lea_pkg`:
  - `LEA_DELTA[4]` constants.
  - `NR`.
  - State enum `lea_ks_state_t`.
  - `rol32(x, n)` function.
- Sub-module `lea_key_round`: combinational single schedule step, (T[0..3], i) → (T'[0..3], rk192). Reusable by the encryption path.
- Storage: 24×192 register array indexed by `i` / `idx`. No RAM macro is required.

## Test plan
- Key 0f1e2d3c4b5a69788796a5b4c3d2e1f0 (bytes; K[0]=3c2d1e0f, K[1]=78695a4b, K[2]=b4a59687, K[3]=f0e1d2c3), `rk_ready`=1 → 24 beats starting in cycle 25, rounds 23→0. Round 0 beat `rk_out` = {02497010, 090d0883, 02497010, 194f7db1, 02497010, 003a0fd4} with `rk_last`=1. Every beat matches the software model.
- Random `rk_ready` backpressure → output stable while stalled, no lost or duplicated beats, `rk_round` strictly decrementing.
- `key_valid` held high during EXPAND/EMIT → `key_ready`=0 throughout. Key accepted in the first IDLE cycle after round 0.
- `replay` after a full stream → identical 24 beats from cycle n+1. `replay` right after reset → ignored, `rk_valid` stays 0.
- `key_valid` and `replay` high together in IDLE → new key expanded, replay ignored.
- `rst_n` pulsed mid-EXPAND and mid-EMIT → all outputs at reset values immediately, `replay` ignored, and a fresh key afterwards yields correct keys.
